// File: rtl/aibnd_red_pkg.sv
// Shared definitions for the IO redundancy shift controller: the FSM state
// encoding and the default chain length / settle time.
package aibnd_red_pkg;

  localparam int RED_NUM_IO_DEF     = 24;
  localparam int RED_SETTLE_CYC_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_APPLY   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RELEASE = 3'd4
  } red_state_t;

endpackage

// File: rtl/aibnd_red_therm_dec.sv
// Thermometer decoder: slice i shifts when i >= idx. An idx of NUM_IO or
// larger selects no slice (all zeros), which is the "no repair" map.
module aibnd_red_therm_dec #(
  parameter int NUM_IO = 24,
  parameter int IDXW   = $clog2(NUM_IO + 1)
) (
  input  logic [IDXW-1:0]   idx,
  output logic [NUM_IO-1:0] mask
);

  // Compare every slice position against the failing index.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      mask[i] = (IDXW'(i) >= idx);
    end
  end

endmodule

// File: rtl/aibnd_red_shift_ctrl.sv
// Redundancy shift controller for the AIB IO buffer chain.
//
// A repair request is taken only in IDLE. The slices are then quiesced
// (digital reset low, analog reset low one clock later), held for
// SETTLE_CYC clocks, the new thermometer shift map is applied in a single
// APPLY cycle, held again for SETTLE_CYC clocks, and released in reverse
// order (analog first, digital one clock later, together with rep_done).
// Counting the clock that samples the request and the clock that raises
// rep_done, a request takes 2*SETTLE_CYC+4 clocks.
//
// Build option: define AIBND_RED_ERR_CHK_EN to reject indices above NUM_IO
// with a one-cycle o_rep_err pulse. Without it there is no o_rep_err port
// and such indices are clamped to NUM_IO (no repair).
//
// Handshake: a request transfers on a clock where i_rep_valid and
// o_rep_ready are both high; the requester holds valid and idx stable until
// then, and valid seen while the controller is busy is simply not acted on.
module aibnd_red_shift_ctrl
  import aibnd_red_pkg::*;
#(
  parameter int NUM_IO     = RED_NUM_IO_DEF,
  parameter int SETTLE_CYC = RED_SETTLE_CYC_DEF,
  parameter int IDXW       = $clog2(NUM_IO + 1)
) (
  input  logic              i_cfg_avmm_clk,
  input  logic              i_cfg_avmm_rst,
  input  logic              i_rep_valid,
  output logic              o_rep_ready,
  input  logic [IDXW-1:0]   i_rep_idx,
  output logic [NUM_IO-1:0] o_shift_en,
  output logic              o_dig_rstb,
  output logic              o_anlg_rstb,
  output logic              o_rep_done,
`ifdef AIBND_RED_ERR_CHK_EN
  output logic              o_rep_err,
`endif
  output red_state_t        o_dbg_state
);

  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [IDXW-1:0] IDX_NONE    = IDXW'(NUM_IO);

  red_state_t        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              first_q, first_d;   // first QUIESCE clock: analog still up
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NUM_IO-1:0] shift_q, shift_d;
  logic              dig_q, dig_d;
  logic              anlg_q, anlg_d;
  logic              done_q, done_d;
  logic [NUM_IO-1:0] mask;
  logic              hs;
`ifdef AIBND_RED_ERR_CHK_EN
  logic              err_q, err_d;
`endif

  assign o_rep_ready = (state_q == ST_IDLE) && !i_cfg_avmm_rst;
  assign hs          = i_rep_valid && o_rep_ready;
  assign o_shift_en  = shift_q;
  assign o_dig_rstb  = dig_q;
  assign o_anlg_rstb = anlg_q;
  assign o_rep_done  = done_q;
  assign o_dbg_state = state_q;
`ifdef AIBND_RED_ERR_CHK_EN
  assign o_rep_err   = err_q;
`endif

  aibnd_red_therm_dec #(
    .NUM_IO (NUM_IO),
    .IDXW   (IDXW)
  ) u_therm_dec (
    .idx  (idx_q),
    .mask (mask)
  );

  // State and output registers; reset aborts any sequence in progress.
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      idx_q   <= IDX_NONE;
      shift_q <= '0;
      dig_q   <= 1'b0;
      anlg_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AIBND_RED_ERR_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      anlg_q  <= anlg_d;
      done_q  <= done_d;
`ifdef AIBND_RED_ERR_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and next-output logic for the quiesce/apply/settle/release sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    dig_d   = dig_q;
    anlg_d  = anlg_q;
    done_d  = 1'b0;
`ifdef AIBND_RED_ERR_CHK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
`ifdef AIBND_RED_ERR_CHK_EN
          if (i_rep_idx > IDX_NONE) begin
            err_d = 1'b1;
          end else begin
            idx_d   = i_rep_idx;
            dig_d   = 1'b0;
            first_d = 1'b1;
            state_d = ST_QUIESCE;
          end
`else
          idx_d   = (i_rep_idx > IDX_NONE) ? IDX_NONE : i_rep_idx;
          dig_d   = 1'b0;
          first_d = 1'b1;
          state_d = ST_QUIESCE;
`endif
        end else if (!anlg_q) begin
          // Coming out of reset: release analog first, digital next clock.
          anlg_d = 1'b1;
        end else if (!dig_q) begin
          dig_d = 1'b1;
        end
      end
      ST_QUIESCE: begin
        if (first_q) begin
          anlg_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
          first_d = 1'b0;
        end else if (cnt_q == 8'd0) begin
          shift_d = mask;
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_APPLY: begin
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          anlg_d  = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RELEASE: begin
        dig_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aibnd_red_shift_ctrl.sv
// Bench for aibnd_red_shift_ctrl: directed repair requests with
// hand-computed shift maps. Drivers push the expected map and the expected
// rep_done clock into queues; a monitor pops and compares on every rep_done
// (and rep_err when AIBND_RED_ERR_CHK_EN is defined).
module tb_aibnd_red_shift_ctrl;
  import aibnd_red_pkg::*;

  localparam int NUM_IO     = 24;
  localparam int SETTLE_CYC = 16;
  localparam int IDXW       = 5;
  localparam int LAT        = 2 * SETTLE_CYC + 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rep_valid = 1'b0;
  logic [IDXW-1:0]   rep_idx = '0;
  logic              rep_ready;
  logic [NUM_IO-1:0] shift_en;
  logic              dig_rstb;
  logic              anlg_rstb;
  logic              rep_done;
  red_state_t        dbg_state;
`ifdef AIBND_RED_ERR_CHK_EN
  logic              rep_err;
  int                err_cyc_q[$];
`endif

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  int viol_order = 0;
  int viol_shift = 0;
  logic [NUM_IO-1:0] exp_q[$];
  int                exp_cyc_q[$];
  logic [NUM_IO-1:0] prev_shift = '0;
  logic [NUM_IO-1:0] mon_exp;
  int                mon_cyc;

  aibnd_red_shift_ctrl #(
    .NUM_IO     (NUM_IO),
    .SETTLE_CYC (SETTLE_CYC),
    .IDXW       (IDXW)
  ) dut (
    .i_cfg_avmm_clk (clk),
    .i_cfg_avmm_rst (rst),
    .i_rep_valid    (rep_valid),
    .o_rep_ready    (rep_ready),
    .i_rep_idx      (rep_idx),
    .o_shift_en     (shift_en),
    .o_dig_rstb     (dig_rstb),
    .o_anlg_rstb    (anlg_rstb),
    .o_rep_done     (rep_done),
`ifdef AIBND_RED_ERR_CHK_EN
    .o_rep_err      (rep_err),
`endif
    .o_dbg_state    (dbg_state)
  );

  // Clock and cycle counter (cyc = number of rising edges seen).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: cycle %0d reached, required finish earlier", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Driver: called at a negedge; holds valid until the handshake clock.
  // hs is the edge number that samples the request. rep_done is expected
  // LAT clocks later counting that edge, i.e. visible at cyc == hs+LAT-1.
  task automatic send(input logic [IDXW-1:0] idx, input logic [NUM_IO-1:0] exp_shift,
                      input bit exp_err, output int hs);
    int w;
    w = 0;
    rep_valid = 1'b1;
    rep_idx   = idx;
    while (!rep_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("handshake_ready", 32'(rep_ready), 32'd1);
    hs = cyc + 1;
    if (exp_err) begin
`ifdef AIBND_RED_ERR_CHK_EN
      err_cyc_q.push_back(hs);
`endif
    end else begin
      exp_q.push_back(exp_shift);
      exp_cyc_q.push_back(hs + LAT - 1);
    end
    @(posedge clk);
    @(negedge clk);
    rep_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    int w;
    w = 0;
    while (cyc < t && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("wait_cyc", cyc, t);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: scoreboard compare on rep_done, plus reset-ordering and
  // map-stability invariants sampled every negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rep_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_cyc = exp_cyc_q.pop_front();
          check("done_shift_en", 32'(shift_en), 32'(mon_exp));
          check("done_latency", cyc, mon_cyc);
          check("done_resets_up", {30'd0, dig_rstb, anlg_rstb}, 32'd3);
        end
      end
`ifdef AIBND_RED_ERR_CHK_EN
      if (rep_err) begin
        if (err_cyc_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
        else check("err_cycle", cyc, err_cyc_q.pop_front());
      end
`endif
      if (!anlg_rstb && dig_rstb) viol_order++;
      if (shift_en != prev_shift && (dig_rstb || anlg_rstb)) viol_shift++;
    end
    prev_shift = shift_en;
  end

  // Directed sequence.
  initial begin
    int h, h2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rep_ready), 32'd0);
    check("rst_shift", 32'(shift_en), 32'd0);
    check("rst_resets", {30'd0, dig_rstb, anlg_rstb}, 32'd0);
    check("rst_done", 32'(rep_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(rep_ready), 32'd1);
    check("post_rst_anlg_first", {30'd0, dig_rstb, anlg_rstb}, 32'd1);
    @(negedge clk);
    check("post_rst_dig", {30'd0, dig_rstb, anlg_rstb}, 32'd3);

    // idx=5: quiesce order, APPLY with both resets low, map 0xFFFFE0.
    send(5'd5, 24'hFFFFE0, 1'b0, h);
    check("q_dig_first", {30'd0, dig_rstb, anlg_rstb}, 32'd1);
    @(negedge clk);
    check("q_anlg_next", {30'd0, dig_rstb, anlg_rstb}, 32'd0);
    wait_cyc(h + SETTLE_CYC + 1);
    check("apply_state", 32'(dbg_state), 32'(ST_APPLY));
    check("apply_resets_low", {30'd0, dig_rstb, anlg_rstb}, 32'd0);
    check("apply_map", 32'(shift_en), 32'hFFFFE0);
    drain();

    // idx=24 (no repair): release order, analog before digital.
    send(5'd24, 24'h000000, 1'b0, h);
    check("q2_dig_first", {30'd0, dig_rstb, anlg_rstb}, 32'd1);
    wait_cyc(h + 2 * SETTLE_CYC + 2);
    check("rel_state", 32'(dbg_state), 32'(ST_RELEASE));
    check("rel_anlg_first", {30'd0, dig_rstb, anlg_rstb}, 32'd1);
    drain();

    // Same map again still runs the whole sequence.
    send(5'd24, 24'h000000, 1'b0, h);
    check("same_map_dig_low", 32'(dig_rstb), 32'd0);
    drain();

    // Highest repairable slice.
    send(5'd23, 24'h800000, 1'b0, h);
    drain();

    // Valid with idx=0 held while busy: accepted only once back in IDLE.
    send(5'd5, 24'hFFFFE0, 1'b0, h);
    send(5'd0, 24'hFFFFFF, 1'b0, h2);
    check("held_hs_cycle", h2, h + LAT);
    drain();

    // Out-of-range index.
`ifdef AIBND_RED_ERR_CHK_EN
    send(5'd30, 24'h000000, 1'b1, h);
    check("err_no_reset_pulse", {30'd0, dig_rstb, anlg_rstb}, 32'd3);
    check("err_map_kept", 32'(shift_en), 32'hFFFFFF);
    check("err_stay_idle", 32'(rep_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("err_map_still", 32'(shift_en), 32'hFFFFFF);
    check("err_q_empty", err_cyc_q.size(), 0);
`else
    send(5'd30, 24'h000000, 1'b0, h);
    check("clamp_dig_low", 32'(dig_rstb), 32'd0);
    drain();
`endif

    // Reset in the middle of SETTLE aborts the sequence.
    send(5'd3, 24'hFFFFF8, 1'b0, h);
    wait_cyc(h + SETTLE_CYC + 5);
    check("mid_state_settle", 32'(dbg_state), 32'(ST_SETTLE));
    rst = 1'b1;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    check("abort_shift", 32'(shift_en), 32'd0);
    check("abort_resets", {30'd0, dig_rstb, anlg_rstb}, 32'd0);
    check("abort_ready", 32'(rep_ready), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_after_shift", 32'(shift_en), 32'd0);
    check("abort_after_resets", {30'd0, dig_rstb, anlg_rstb}, 32'd3);
    repeat (LAT) @(negedge clk);
    check("abort_no_done", 32'(rep_done), 32'd0);

    check("order_violations", viol_order, 0);
    check("shift_violations", viol_shift, 0);
    check("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
